dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, data word width.
REQ-002 Parameter ADDR_WIDTH, default 8, data-memory word address width (256 words).
REQ-003 Parameter MAX_WAIT, default 4, cycles port 1 may be denied before a forced grant; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 p0_req  in  1  CPU MEM-stage access request (port 0).
REQ-007 p0_we  in  1  port 0 write (1) / read (0).
REQ-008 p0_addr  in  ADDR_WIDTH  port 0 address.
REQ-009 p0_wdata  in  DATA_WIDTH  port 0 write data.
REQ-010 p0_gnt  out  1  port 0 access accepted this cycle.
REQ-011 p0_rvalid  out  1  port 0 read data valid.
REQ-012 p0_rdata  out  DATA_WIDTH  port 0 read data.
REQ-013 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same directions, widths and meanings for port 1 (DMA/debug loader).
REQ-014 cpu_stall  out  1  p0_req & ~p0_gnt; holds the CPU pipeline.
REQ-015 mem_read, mem_write  out  1 each  data-memory strobes.
REQ-016 mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_rdata  in  DATA_WIDTH (asynchronous read, valid in the cycle mem_read is high).

Function
REQ-017 At most one of p0_gnt, p1_gnt SHALL be high in any cycle; grant is combinational from current requests and state.
REQ-018 Request held high until granted; requester deasserts or presents next access the cycle after gnt.
REQ-019 FSM states: P0_PRI (default) and P1_FORCE.
REQ-020 In P0_PRI: p0_req high -> grant port 0; else p1_req high -> grant port 1; else no grant.
REQ-021 wait_cnt (4 bits) SHALL increment each cycle p1_req is high and p1_gnt low, clear on p1_gnt or p1_req low, saturating at 15.
REQ-022 When wait_cnt reaches MAX_WAIT-1 while denied, next state SHALL be P1_FORCE.
REQ-023 In P1_FORCE: grant port 1 unconditionally if p1_req high (p0 stalls); return to P0_PRI next cycle; if p1_req dropped, return to P0_PRI with no port-1 grant.
REQ-024 Granted access drives mem_read = ~we, mem_write = we, mem_addr, mem_wdata from the granted port; all mem outputs zero when no grant.
REQ-025 On a granted read, mem_rdata SHALL be registered into the granted port's rdata and its rvalid pulsed high for exactly one cycle, next cycle (latency 1).
REQ-026 rdata holds last read value until the next read on that port; rvalid low after writes.
REQ-027 Back-to-back grants to alternating ports SHALL each return correct data; no dead cycle between accesses.
REQ-028 Write and read of the same address in consecutive cycles: the read returns the written value (memory write occurs at grant edge).

Reset
REQ-029 On reset: state = P0_PRI, wait_cnt = 0, p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0.
REQ-030 Reset asserted mid-access SHALL suppress any pending rvalid; gnt outputs remain combinational but mem_read/mem_write forced 0 while reset high.

Structure
REQ-031 Shared package holds FSM state encoding (P0_PRI = 1'b0, P1_FORCE = 1'b1) and the port-select constants.
REQ-032 Single sub-module arb_wait_ctr (saturating wait counter with threshold compare) is natural; everything else is flat.

Verification
REQ-033 Only p1 read addr 0x10 (mem 0x1234) -> p1_gnt same cycle, p1_rvalid next cycle, p1_rdata = 0x1234.
REQ-034 p0 and p1 both request continuously, MAX_WAIT=4 -> p0 granted 4 cycles, p1 granted 5th, pattern repeats; cpu_stall high exactly on p1 grant cycles.
REQ-035 p0 write 0xBEEF to 0x20, next cycle p1 read 0x20 -> p1_rdata = 0xBEEF.
REQ-036 p1 drops request in the cycle state is P1_FORCE -> no grant, p0 granted next cycle, wait_cnt = 0.
REQ-037 Reset asserted the cycle after a p0 read grant -> p0_rvalid stays 0, state P0_PRI, mem strobes 0.
REQ-038 Randomized dual-port traffic for 10k cycles vs reference memory model -> no mismatches, never two grants in one cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared FSM state encoding and port-select constants for the
//            data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        P0_PRI   = 1'b0,
        P1_FORCE = 1'b1
    } arb_state_e;

    // One-hot grant vector: bit 0 = port 0, bit 1 = port 1
    localparam logic [1:0] c_sel_none = 2'b00;
    localparam logic [1:0] c_sel_p0   = 2'b01;
    localparam logic [1:0] c_sel_p1   = 2'b10;

    localparam logic [3:0] c_wait_max = 4'd15;

endpackage
`default_nettype wire

// File: rtl/arb_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module   : arb_wait_ctr
// Brief    : Saturating count of consecutive port-1 denials with a threshold
//            flag that triggers the forced grant.
// Revision : 1.0 - initial release
// ============================================================================
module arb_wait_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic denied,
    output logic at_thresh
);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("arb_wait_ctr: MAX_WAIT must be in 1..15");
    end

    localparam logic [3:0] c_thresh = 4'(MAX_WAIT - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (!denied) begin
            r_cnt <= 4'd0;
        end else if (r_cnt != c_wait_max) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign at_thresh = (r_cnt == c_thresh);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port data-memory arbiter: CPU (port 0) has priority, port 1
//            is force-granted after MAX_WAIT consecutive denials.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  cpu_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            r_state;
    logic [1:0]            w_sel;
    logic                  w_p1_denied;
    logic                  w_at_thresh;
    logic                  r_p0_rvalid;
    logic                  r_p1_rvalid;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;

    // In P1_FORCE port 0 is never granted, even if port 1 has gone away
    always_comb begin
        w_sel = c_sel_none;
        unique case (r_state)
            P0_PRI: begin
                if (p0_req)      w_sel = c_sel_p0;
                else if (p1_req) w_sel = c_sel_p1;
            end
            P1_FORCE: begin
                if (p1_req)      w_sel = c_sel_p1;
            end
            default: w_sel = c_sel_none;
        endcase
    end

    assign p0_gnt      = w_sel[0];
    assign p1_gnt      = w_sel[1];
    assign cpu_stall   = p0_req & ~p0_gnt;
    assign w_p1_denied = p1_req & ~p1_gnt;

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk       (clk),
        .reset     (reset),
        .denied    (w_p1_denied),
        .at_thresh (w_at_thresh)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= P0_PRI;
        end else begin
            unique case (r_state)
                P0_PRI:   if (w_p1_denied && w_at_thresh) r_state <= P1_FORCE;
                P1_FORCE: r_state <= P0_PRI;
                default:  r_state <= P0_PRI;
            endcase
        end
    end

    // Strobes are gated by reset so no access reaches memory while it is held
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_read  = ~p0_we & ~reset;
            mem_write =  p0_we & ~reset;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_read  = ~p1_we & ~reset;
            mem_write =  p1_we & ~reset;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= p0_gnt & ~p0_we;
            r_p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) r_p0_rdata <= mem_rdata;
            if (p1_gnt && !p1_we) r_p1_rdata <= mem_rdata;
        end
    end

    // A read captured just before reset rises must not be reported
    assign p0_rvalid = r_p0_rvalid & ~reset;
    assign p1_rvalid = r_p1_rvalid & ~reset;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed and random self-checking bench for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int MAX_WAIT   = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_WIDTH-1:0] p0_addr, p1_addr;
    logic [DATA_WIDTH-1:0] p0_wdata, p1_wdata;
    logic                  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata, p1_rdata;
    logic                  cpu_stall, mem_read, mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

    logic [DATA_WIDTH-1:0] mem     [0:255];
    logic [DATA_WIDTH-1:0] ref_mem [0:255];
    logic                  preload;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .cpu_stall (cpu_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory: word i holds 0x5A00|i, except 0x10 which holds 0x1234
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 16) ? 16'h1234 : (16'h5A00 | 16'(i));
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       g0, g1, ev0, ev1;
        logic [15:0] ed0, ed1;
        int         w1;

        reset = 1'b1; preload = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        repeat (3) tick();
        preload = 1'b0;
        #2;
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_rdata",  p0_rdata, 0);
        chk("rst_p1_rdata",  p1_rdata, 0);
        chk("rst_state",     32'(dut.r_state), 32'(P0_PRI));
        chk("rst_wait_cnt",  dut.u_wait_ctr.r_cnt, 0);

        // Lone port-1 read of 0x10
        tick(); reset = 0;
        p1_req = 1; p1_we = 0; p1_addr = 8'h10;
        #2;
        chk("p1rd_gnt",      p1_gnt, 1);
        chk("p1rd_p0_gnt",   p0_gnt, 0);
        chk("p1rd_mem_read", mem_read, 1);
        chk("p1rd_mem_addr", mem_addr, 8'h10);
        chk("p1rd_stall",    cpu_stall, 0);
        tick(); p1_req = 0;
        #2;
        chk("p1rd_rvalid",   p1_rvalid, 1);
        chk("p1rd_rdata",    p1_rdata, 16'h1234);
        tick(); #2;
        chk("p1rd_rvalid_pulse", p1_rvalid, 0);
        chk("p1rd_rdata_hold",   p1_rdata, 16'h1234);

        // Port-0 write then port-1 read of the same address
        tick();
        p0_req = 1; p0_we = 1; p0_addr = 8'h20; p0_wdata = 16'hBEEF;
        #2;
        chk("wr_p0_gnt",    p0_gnt, 1);
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_read",  mem_read, 0);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
        tick();
        p0_req = 0; p0_we = 0;
        p1_req = 1; p1_we = 0; p1_addr = 8'h20;
        #2;
        chk("raw_p1_gnt",     p1_gnt, 1);
        chk("raw_p0_rvalid",  p0_rvalid, 0);
        tick(); p1_req = 0;
        #2;
        chk("raw_p1_rvalid", p1_rvalid, 1);
        chk("raw_p1_rdata",  p1_rdata, 16'hBEEF);

        // Both ports request continuously: 4 port-0 grants, then 1 port-1 grant
        tick();
        p0_req = 1; p0_we = 0; p0_addr = 8'h30;
        p1_req = 1; p1_we = 0; p1_addr = 8'h31;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk($sformatf("cont_p0_gnt[%0d]", k), p0_gnt,    (k % 5) != 4);
            chk($sformatf("cont_p1_gnt[%0d]", k), p1_gnt,    (k % 5) == 4);
            chk($sformatf("cont_stall[%0d]", k),  cpu_stall, (k % 5) == 4);
            tick();
        end
        p0_req = 0; p1_req = 0;
        #2;
        chk("cont_p1_rvalid", p1_rvalid, 1);
        chk("cont_p1_rdata",  p1_rdata, 16'h5A31);
        chk("cont_p0_rdata",  p0_rdata, 16'h5A30);

        // Port 1 withdraws in the forced cycle
        tick();
        p0_req = 1; p0_addr = 8'h40;
        p1_req = 1; p1_addr = 8'h41;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("drop_p0_gnt[%0d]", k), p0_gnt, 1);
            if (k == 3) chk("drop_wait_cnt_thresh", dut.u_wait_ctr.r_cnt, 3);
            tick();
        end
        p1_req = 0;
        #2;
        chk("drop_state_force", 32'(dut.r_state), 32'(P1_FORCE));
        chk("drop_p0_gnt",      p0_gnt, 0);
        chk("drop_p1_gnt",      p1_gnt, 0);
        chk("drop_stall",       cpu_stall, 1);
        tick(); #2;
        chk("drop_p0_gnt_next", p0_gnt, 1);
        chk("drop_state_back",  32'(dut.r_state), 32'(P0_PRI));
        chk("drop_wait_cnt",    dut.u_wait_ctr.r_cnt, 0);

        // Reset the cycle after a port-0 read grant
        tick();
        reset = 1;
        #2;
        chk("rstmid_p0_rvalid", p0_rvalid, 0);
        chk("rstmid_p0_gnt",    p0_gnt, 1);
        chk("rstmid_mem_read",  mem_read, 0);
        chk("rstmid_mem_write", mem_write, 0);
        tick(); #2;
        chk("rstmid_state",     32'(dut.r_state), 32'(P0_PRI));
        chk("rstmid_p0_rvalid2", p0_rvalid, 0);
        chk("rstmid_p0_rdata",  p0_rdata, 0);
        reset = 0; p0_req = 0;
        tick();

        // Random dual-port traffic against a reference memory
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        g0 = 0; g1 = 0; ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0; w1 = 0;
        for (int n = 0; n < 10000; n++) begin
            if (!p0_req || g0) begin
                p0_req = 1'($urandom_range(0, 1)); p0_we = 1'($urandom_range(0, 1));
                p0_addr = 8'($urandom_range(0, 15)); p0_wdata = 16'($urandom);
            end
            if (!p1_req || g1) begin
                p1_req = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
                p1_addr = 8'($urandom_range(0, 15)); p1_wdata = 16'($urandom);
            end
            #2;
            chk("rnd_p0_rvalid", p0_rvalid, ev0);
            chk("rnd_p1_rvalid", p1_rvalid, ev1);
            if (ev0) chk("rnd_p0_rdata", p0_rdata, ed0);
            if (ev1) chk("rnd_p1_rdata", p1_rdata, ed1);
            g0 = p0_gnt; g1 = p1_gnt;
            chk("rnd_two_gnt", g0 & g1, 0);
            chk("rnd_gnt_no_req", (g0 & ~p0_req) | (g1 & ~p1_req), 0);
            w1 = (p1_req && !g1) ? w1 + 1 : 0;
            chk("rnd_p1_starved", w1 > MAX_WAIT, 0);
            ev0 = g0 & ~p0_we; ev1 = g1 & ~p1_we;
            if (ev0) ed0 = ref_mem[p0_addr];
            if (ev1) ed1 = ref_mem[p1_addr];
            if (g0 && p0_we) ref_mem[p0_addr] = p0_wdata;
            if (g1 && p1_we) ref_mem[p1_addr] = p1_wdata;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
